led_page_scheduler: RTL and testbench

Controller that sequences the 8-bit LED page-select mux for the R/I-type CPU board display. It produces the 4-bit page select (`sela`) and a registered snapshot of the two 32-bit operands and the ALU flags. It offers two modes: auto-scan, where pages rotate on a timer, and manual, where a debounced button steps the page. A freeze toggle holds the snapshot so a value can be read off the LEDs while the CPU keeps running. It sits between the CPU/ALU outputs and the LED page mux.

---
 rtl/led_ctrl_pkg.sv | 15 +
 rtl/btn_debounce.sv | 32 +++
 rtl/led_page_scheduler.sv | 88 ++++++++
 tb/tb_led_page_scheduler.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared page constants, mode encoding and select width for the LED page scheduler.
package led_ctrl_pkg;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] PAGE_A0    = 4'd0;
    localparam logic [SEL_W-1:0] PAGE_A1    = 4'd1;
    localparam logic [SEL_W-1:0] PAGE_A2    = 4'd2;
    localparam logic [SEL_W-1:0] PAGE_A3    = 4'd3;
    localparam logic [SEL_W-1:0] PAGE_B0    = 4'd4;
    localparam logic [SEL_W-1:0] PAGE_B1    = 4'd5;
    localparam logic [SEL_W-1:0] PAGE_B2    = 4'd6;
    localparam logic [SEL_W-1:0] PAGE_B3    = 4'd7;
    localparam logic [SEL_W-1:0] PAGE_FLAGS = 4'd8;
    localparam logic [SEL_W-1:0] PAGE_LAST  = PAGE_FLAGS;
    typedef enum logic {MODE_AUTO, MODE_MANUAL} mode_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability counter; one-cycle pulse on an accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2, lvl, done;
    logic [CW-1:0] cnt;
    // Pulse is decoded from registered state so the consumer reacts on the acceptance edge.
    assign done = (s2 != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign press_pulse = done && s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            if (s2 == lvl) cnt <= '0;
            else if (done) begin
                lvl <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_page_scheduler.sv
// led_page_scheduler: AUTO/MANUAL page sequencer for the LED mux with a freezable operand/flag snapshot.
module led_page_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_PAGES       = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_next,
    input  logic             btn_mode,
    input  logic             btn_freeze,
    input  logic [31:0]      dina_in,
    input  logic [31:0]      dinb_in,
    input  logic             ofa_in,
    input  logic             zfa_in,
    output logic [31:0]      dina_out,
    output logic [31:0]      dinb_out,
    output logic             ofa_out,
    output logic             zfa_out,
    output logic [SEL_W-1:0] sela,
    output logic             auto_mode,
    output logic             frozen
);
    localparam int DW = $clog2(DWELL_CYCLES);
    logic next_pulse, mode_pulse, freeze_pulse;
    mode_t mode, mode_n;
    logic [SEL_W-1:0] sela_n, sela_inc;
    logic [DW-1:0] dwell, dwell_n;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_next), .press_pulse(next_pulse));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .press_pulse(mode_pulse));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_freeze (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_freeze), .press_pulse(freeze_pulse));

    assign sela_inc  = (sela == PAGE_LAST) ? PAGE_A0 : sela + 1'b1;
    assign auto_mode = (mode == MODE_AUTO);

    // A mode pulse wins over both the dwell terminal count and a next pulse.
    always_comb begin
        mode_n  = mode;
        sela_n  = sela;
        dwell_n = '0;
        if (mode_pulse) mode_n = (mode == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
        else if (mode == MODE_AUTO) begin
            dwell_n = (dwell == DW'(DWELL_CYCLES - 1)) ? '0 : dwell + 1'b1;
            sela_n  = (dwell == DW'(DWELL_CYCLES - 1)) ? sela_inc : sela;
        end else sela_n = next_pulse ? sela_inc : sela;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode  <= MODE_AUTO;
            sela  <= PAGE_A0;
            dwell <= '0;
        end else begin
            mode  <= mode_n;
            sela  <= sela_n;
            dwell <= dwell_n;
        end
    end

    // The freeze pulse cycle still loads, so the held value is that cycle's inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen   <= 1'b0;
            dina_out <= '0;
            dinb_out <= '0;
            ofa_out  <= 1'b0;
            zfa_out  <= 1'b0;
        end else begin
            if (freeze_pulse) frozen <= !frozen;
            if (!frozen) begin
                dina_out <= dina_in;
                dinb_out <= dinb_in;
                ofa_out  <= ofa_in;
                zfa_out  <= zfa_in;
            end
        end
    end

    if (NUM_PAGES != 9) begin : g_bad_pages
        $error("NUM_PAGES must be 9");
    end
endmodule

// File: tb/tb_led_page_scheduler.sv
// tb_led_page_scheduler: directed checks of page sequencing, debounce, mode switching, freeze and reset.
module tb_led_page_scheduler;
    logic clk = 0, rst_n = 0;
    logic btn_next = 0, btn_mode = 0, btn_freeze = 0;
    logic [31:0] dina_in = 0, dinb_in = 0, dina_out, dinb_out;
    logic ofa_in = 0, zfa_in = 0, ofa_out, zfa_out, auto_mode, frozen;
    logic [3:0] sela;
    int checks = 0, errors = 0;

    led_page_scheduler #(.DWELL_CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_mode(btn_mode),
        .btn_freeze(btn_freeze), .dina_in(dina_in), .dinb_in(dinb_in),
        .ofa_in(ofa_in), .zfa_in(zfa_in), .dina_out(dina_out), .dinb_out(dinb_out),
        .ofa_out(ofa_out), .zfa_out(zfa_out), .sela(sela), .auto_mode(auto_mode),
        .frozen(frozen));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_next(input logic [3:0] exp);
        btn_next = 1;
        step(6);
        btn_next = 0;
        step(6);
        chk("next_press", sela, exp);
    endtask

    initial begin
        step(2);
        chk("rst_sela", sela, 0);
        chk("rst_auto", auto_mode, 1);
        chk("rst_frozen", frozen, 0);
        chk("rst_dina", dina_out, 0);
        rst_n = 1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            chk($sformatf("auto_k%0d", k), sela, (k / 4) % 9);
        end
        chk("auto_mode1", auto_mode, 1);
        chk("frozen1", frozen, 0);
        // mode button: raw edge after edge 45, toggle lands on edge 50 while sela=3
        step(5);
        btn_mode = 1;
        step(4);
        chk("mode_before", auto_mode, 1);
        step(1);
        chk("mode_toggle", auto_mode, 0);
        chk("mode_sela", sela, 3);
        step(5);
        btn_mode = 0;
        step(10);
        chk("mode_once", auto_mode, 0);
        chk("manual_hold", sela, 3);
        press_next(4);
        press_next(5);
        press_next(6);
        press_next(7);
        press_next(8);
        press_next(0);
        for (int i = 0; i < 5; i++) begin
            btn_next = 1;
            step(2);
            btn_next = 0;
            step(2);
        end
        step(5);
        chk("glitch", sela, 0);
        dina_in = 32'hDEADBEEF;
        dinb_in = 32'hCAFEF00D;
        ofa_in = 1;
        zfa_in = 1;
        step(1);
        chk("snap_a", dina_out, 32'hDEADBEEF);
        chk("snap_b", dinb_out, 32'hCAFEF00D);
        chk("snap_flags", {ofa_out, zfa_out}, 2'b11);
        btn_freeze = 1;
        step(4);
        chk("frz_early", frozen, 0);
        step(1);
        chk("frz_set", frozen, 1);
        dina_in = 32'h12345678;
        ofa_in = 0;
        step(3);
        chk("frz_hold_a", dina_out, 32'hDEADBEEF);
        chk("frz_hold_of", ofa_out, 1);
        btn_freeze = 0;
        step(6);
        chk("frz_hold2", dina_out, 32'hDEADBEEF);
        chk("frz_still", frozen, 1);
        btn_freeze = 1;
        step(5);
        chk("unfrz", frozen, 0);
        chk("unfrz_hold", dina_out, 32'hDEADBEEF);
        step(1);
        chk("unfrz_load", dina_out, 32'h12345678);
        btn_freeze = 0;
        step(6);
        btn_mode = 1;
        btn_next = 1;
        step(4);
        chk("sim_pre", auto_mode, 0);
        step(1);
        chk("sim_auto", auto_mode, 1);
        chk("sim_sela", sela, 0);
        step(3);
        chk("sim_dwell", sela, 0);
        step(1);
        chk("sim_adv", sela, 1);
        btn_mode = 0;
        btn_next = 0;
        btn_freeze = 1;
        step(5);
        chk("r_frozen", frozen, 1);
        btn_freeze = 0;
        step(13);
        chk("r_sela", sela, 5);
        chk("r_held", dina_out, 32'h12345678);
        #2 rst_n = 0;
        #1;
        chk("ar_sela", sela, 0);
        chk("ar_frozen", frozen, 0);
        chk("ar_auto", auto_mode, 1);
        chk("ar_dina", dina_out, 0);
        chk("ar_dinb", dinb_out, 0);
        chk("ar_flags", {ofa_out, zfa_out}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
